// File: rtl/cache_req_frontend_pkg.sv
// Shared types and constants for the cache request front-end.
// Response bundle layout and the issue-space rule live here.
package cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int INDEX_LSB = 2;
  localparam int INDEX_MSB = 3;
  localparam int TAG_LSB   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;
  } rsp_t;

  // True when the response buffer still has room once S1 lands.
  function automatic logic can_issue(
    input logic [1:0] occ,
    input logic       pop,
    input logic       push
  );
    logic [2:0] w_nxt;
    w_nxt = {1'b0, occ} - {2'b0, pop} + {2'b0, push};
    return w_nxt < 3'd2;
  endfunction

endpackage

// File: rtl/cache_req_frontend_if.sv
// Generic valid/ready channel carrying a W-bit payload.
// master drives valid/data, slave drives ready.
interface cache_req_frontend_if #(
  parameter int W = 32
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/cache_req_frontend_sync_fifo.sv
// Synchronous FIFO with occupancy count, power-of-2 depth.
// Storage is cleared on reset so the head reads zero when empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_cnt != FULL);
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cache_req_frontend.sv
// Request FIFO -> issue register -> cache -> 2-entry response buffer.
// Also keeps saturating hit/miss statistics.
module cache_req_frontend
  import cache_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  cache_req_frontend_if.slave  req,
  cache_req_frontend_if.master rsp,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_out,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy
);

  localparam int QW = $clog2(REQ_DEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(REQ_DEPTH);

  logic              r_live;
  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [QW:0]       w_q_cnt;
  logic [ADDR_W-1:0] w_q_head;
  logic [1:0]        w_b_cnt;
  rsp_t              w_b_head;
  rsp_t              w_b_in;
  logic              w_req_push;
  logic              w_rsp_pop;
  logic              w_issue;

  // r_live holds ready low through reset and its first released edge.
  assign req.ready  = r_live && (w_q_cnt < QFULL);
  assign w_req_push = req.valid && req.ready;
  assign rsp.valid  = (w_b_cnt != '0);
  assign rsp.data   = w_b_head;
  assign w_rsp_pop  = rsp.valid && rsp.ready;
  assign w_issue    = (w_q_cnt != '0) &&
                      can_issue(w_b_cnt, w_rsp_pop, r_s1_valid);

  assign w_b_in = '{addr: r_cache_addr,
                    data: cache_out,
                    hit:  cache_hit};

  assign cache_addr = r_cache_addr;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign busy       = (w_q_cnt != '0) || r_s1_valid || rsp.valid;

  sync_fifo #(
    .W     (ADDR_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_push),
    .i_wdata (req.data),
    .i_pop   (w_issue),
    .o_rdata (w_q_head),
    .o_count (w_q_cnt)
  );

  sync_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (2)
  ) u_rsp_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s1_valid),
    .i_wdata (w_b_in),
    .i_pop   (w_rsp_pop),
    .o_rdata (w_b_head),
    .o_count (w_b_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live       <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_cache_addr <= '0;
    end else begin
      r_live     <= 1'b1;
      r_s1_valid <= w_issue;
      if (w_issue) r_cache_addr <= w_q_head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_s1_valid) begin
      if (cache_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_req_frontend.sv
// Bench for cache_req_frontend with a 2-way, 4-set LRU cache stub.
// Directed scenarios, each task checks its own expectations.
module tb_cache_req_frontend;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_frontend_if #(.W(32))            req_if ();
  cache_req_frontend_if #(.W($bits(rsp_t))) rsp_if ();
  cache_req_frontend_if #(.W(32))            req2 ();
  cache_req_frontend_if #(.W($bits(rsp_t))) rsp2 ();

  logic [31:0] cache_addr, cache_out;
  logic        cache_hit;
  logic [15:0] hit_cnt, miss_cnt;
  logic        busy;

  logic [31:0] cache_addr2;
  logic [31:0] cache_out2 = 32'h0;
  logic        cache_hit2 = 1'b1;
  logic [3:0]  hit_cnt2, miss_cnt2;
  logic        busy2;

  cache_req_frontend #(.REQ_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req_if), .rsp(rsp_if),
    .cache_addr(cache_addr), .cache_hit(cache_hit),
    .cache_out(cache_out), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .busy(busy)
  );

  cache_req_frontend #(.REQ_DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req(req2), .rsp(rsp2),
    .cache_addr(cache_addr2), .cache_hit(cache_hit2),
    .cache_out(cache_out2), .hit_cnt(hit_cnt2),
    .miss_cnt(miss_cnt2), .busy(busy2)
  );

  rsp_t rv;
  assign rv = rsp_if.data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  rsp_t got_q[$];
  int   got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst && rsp_if.valid && rsp_if.ready) begin
      got_q.push_back(rv);
      got_cyc.push_back(cyc);
    end

  // Cache stub: lookup on negedge, data = addr>>2, c_lru = victim way.
  logic        c_v   [4][2];
  logic [27:0] c_tg  [4][2];
  logic        c_lru [4];
  logic [1:0]  si;
  logic [27:0] tg;
  logic        vw;
  assign si = cache_addr[3:2];
  assign tg = cache_addr[31:4];
  assign vw = !c_v[si][0] ? 1'b0 : (!c_v[si][1] ? 1'b1 : c_lru[si]);

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 4; s++) begin
        c_v[s][0] <= 1'b0;
        c_v[s][1] <= 1'b0;
        c_lru[s]  <= 1'b0;
      end
      cache_hit <= 1'b0;
      cache_out <= 32'h0;
    end else begin
      if (c_v[si][0] && c_tg[si][0] == tg) begin
        cache_hit <= 1'b1;
        c_lru[si] <= 1'b1;
      end else if (c_v[si][1] && c_tg[si][1] == tg) begin
        cache_hit <= 1'b1;
        c_lru[si] <= 1'b0;
      end else begin
        cache_hit    <= 1'b0;
        c_v[si][vw]  <= 1'b1;
        c_tg[si][vw] <= tg;
        c_lru[si]    <= ~vw;
      end
      cache_out <= cache_addr >> 2;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_if.valid = 1'b0;
    rsp_if.ready = 1'b1;
    req2.valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_if.valid, busy, req_if.ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got v/b/r %b exp 000",
               {rsp_if.valid, busy, req_if.ready});
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h/%h exp 0/0", hit_cnt, miss_cnt);
    end
    checks++;
    if (cache_addr !== 32'h0 || rv !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %h rsp %h exp 0",
               cache_addr, rv);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (req_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pre_edge got %b exp 0", req_if.ready);
    end
    step();
    checks++;
    if (req_if.ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_post_edge got r %b b %b exp 1 0",
               req_if.ready, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_if.valid = 1'b1;
    req_if.data  = 32'h40;
    step();
    req_if.valid = 1'b0;
    checks++;
    if (rsp_if.valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_k got v %b b %b exp 0 1", rsp_if.valid, busy);
    end
    step();
    checks++;
    if (rsp_if.valid !== 1'b0 || cache_addr !== 32'h40) begin
      errors++;
      $display("FAIL lat_k1 got v %b addr %h exp 0 40",
               rsp_if.valid, cache_addr);
    end
    step();
    checks++;
    if (rsp_if.valid !== 1'b1 || rv.addr !== 32'h40 ||
        rv.data !== 32'h10 || rv.hit !== 1'b0) begin
      errors++;
      $display("FAIL first_miss got v %b %h %h %b exp 1 40 10 0",
               rsp_if.valid, rv.addr, rv.data, rv.hit);
    end
    checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL first_cnt got %0d/%0d exp 0/1", hit_cnt, miss_cnt);
    end
    step();
    checks++;
    if (rsp_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_once got v %b exp 0", rsp_if.valid);
    end
    req_if.valid = 1'b1;
    step();
    req_if.valid = 1'b0;
    step();
    step();
    checks++;
    if (rsp_if.valid !== 1'b1 || rv.hit !== 1'b1 ||
        rv.data !== 32'h10 || hit_cnt !== 16'd1) begin
      errors++;
      $display("FAIL repeat_hit got v %b hit %b d %h hc %0d exp 1 1 10 1",
               rsp_if.valid, rv.hit, rv.data, hit_cnt);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL idle got b %b mc %0d exp 0 1", busy, miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] d [4];
    a = '{32'h40, 32'h80, 32'hC0, 32'h40};
    d = '{32'h10, 32'h20, 32'h30, 32'h10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_if.valid = 1'b1;
      req_if.data  = a[i];
      step();
    end
    req_if.valid = 1'b0;
    for (int i = 0; i < 30 && got_q.size() < 4; i++) step();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i].addr !== a[i] || got_q[i].data !== d[i] ||
            got_q[i].hit !== 1'b0 || got_cyc[i] != got_cyc[0] + i) begin
          errors++;
          $display("FAIL b2b_%0d got %h %h %b c%0d exp %h %h 0 c%0d",
                   i, got_q[i].addr, got_q[i].data, got_q[i].hit,
                   got_cyc[i], a[i], d[i], got_cyc[0] + i);
        end
      end
    end
    checks++;
    if (miss_cnt !== 16'd4 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL b2b_cnt got %0d/%0d exp 0/4", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] b [8];
    logic [31:0] d [8];
    logic        h [8];
    logic        acc;
    int          n;
    b = '{32'h100, 32'h104, 32'h108, 32'h10C,
          32'h100, 32'h104, 32'h200, 32'h100};
    d = '{32'h40, 32'h41, 32'h42, 32'h43,
          32'h40, 32'h41, 32'h80, 32'h40};
    h = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    rsp_if.ready = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      req_if.valid = (n < 8);
      req_if.data  = b[n % 8];
      acc = req_if.valid && req_if.ready;
      step();
      if (acc) n++;
    end
    checks++;
    if (n != 6 || req_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill got acc %0d rdy %b exp 6 0", n, req_if.ready);
    end
    checks++;
    if (rsp_if.valid !== 1'b1 || rv.addr !== b[0] || got_q.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got v %b %h n%0d exp 1 %h n0",
               rsp_if.valid, rv.addr, got_q.size(), b[0]);
    end
    rsp_if.ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      req_if.valid = (n < 8);
      req_if.data  = b[n % 8];
      acc = req_if.valid && req_if.ready;
      step();
      if (acc) n++;
    end
    req_if.valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d exp 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i].addr !== b[i] || got_q[i].data !== d[i] ||
            got_q[i].hit !== h[i]) begin
          errors++;
          $display("FAIL bp_%0d got %h %h %b exp %h %h %b", i,
                   got_q[i].addr, got_q[i].data, got_q[i].hit,
                   b[i], d[i], h[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_if.ready = 1'b0;
    req_if.valid = 1'b1;
    req_if.data  = 32'h44;
    step();
    req_if.valid = 1'b0;
    step();
    step();
    checks++;
    if (rsp_if.valid !== 1'b1 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_pre got v %b mc %0d exp 1 1",
               rsp_if.valid, miss_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_if.valid, busy, req_if.ready} !== 3'b000 ||
        {hit_cnt, miss_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL mid_async got v/b/r %b cnt %h exp 000 0",
               {rsp_if.valid, busy, req_if.ready}, {hit_cnt, miss_cnt});
    end
    step();
    rst = 1'b1;
    step();
    rsp_if.ready = 1'b1;
    req_if.valid = 1'b1;
    step();
    req_if.valid = 1'b0;
    step();
    step();
    checks++;
    if (rsp_if.valid !== 1'b1 || rv.addr !== 32'h44 ||
        rv.hit !== 1'b0 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_after got v %b %h hit %b mc %0d exp 1 44 0 1",
               rsp_if.valid, rv.addr, rv.hit, miss_cnt);
    end
    step();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL mid_stale got %0d rsp exp 1", got_q.size());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    cache_hit2 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      req2.valid = 1'b1;
      req2.data  = 32'h300 + 32'(i * 4);
      step();
    end
    req2.valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (hit_cnt2 !== 4'd15 || miss_cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL sat_hit got %0d/%0d exp 15/0", hit_cnt2, miss_cnt2);
    end
    cache_hit2 = 1'b0;
    req2.valid = 1'b1;
    step();
    req2.valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (hit_cnt2 !== 4'd15 || miss_cnt2 !== 4'd1 || busy2 !== 1'b0 ||
        cache_addr2 !== 32'h344) begin
      errors++;
      $display("FAIL sat_miss got %0d/%0d b %b a %h exp 15/1 0 344",
               hit_cnt2, miss_cnt2, busy2, cache_addr2);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 80; c++) begin
      req_if.valid = 1'b1;
      req_if.data  = 32'h1000 + 32'(n * 4);
      rsp_if.ready = 1'($urandom_range(0, 1));
      if (req_if.ready) begin
        exp_q.push_back(req_if.data);
        n++;
      end
      step();
    end
    req_if.valid = 1'b0;
    rsp_if.ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) step();
    step();
    step();
    checks++;
    if (got_q.size() != exp_q.size() || n < 20) begin
      errors++;
      $display("FAIL rnd_count got %0d exp %0d (acc %0d)",
               got_q.size(), exp_q.size(), n);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i].addr !== exp_q[i] ||
            got_q[i].data !== (exp_q[i] >> 2)) begin
          errors++;
          $display("FAIL rnd_%0d got %h %h exp %h %h", i,
                   got_q[i].addr, got_q[i].data, exp_q[i], exp_q[i] >> 2);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    req_if.valid = 1'b0;
    req_if.data  = 32'h0;
    rsp_if.ready = 1'b1;
    req2.valid   = 1'b0;
    req2.data    = 32'h0;
    rsp2.ready   = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_req_frontend.md
Name: cache_req_frontend

Overview:
- Request front-end that sits directly upstream of the 2-way, 4-set cache. It accepts addresses from a producer over a valid/ready interface and buffers them in a request FIFO.
- It drives one address per clock onto the cache address input. The cache samples that address on negedge.
- It captures the cache's hit/out results on the following posedge and returns them over a valid/ready response interface.
- It keeps saturating hit and miss statistics counters.

Parameters:
- REQ_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  producer offers req_addr.
- req_ready  out  1  FIFO can accept this cycle.
- req_addr  in  32  byte address to look up.
- cache_addr  out  32  registered address to the cache; stable across negedge.
- cache_hit  in  1  cache hit result, valid after negedge.
- cache_out  in  32  cache data result, valid after negedge.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_addr  out  32  address the response belongs to.
- rsp_data  out  32  captured cache_out.
- rsp_hit  out  1  captured cache_hit.
- hit_cnt  out  CNT_W  saturating count of hits.
- miss_cnt  out  CNT_W  saturating count of misses.
- busy  out  1  set when the FIFO, S1 or the response buffer is non-empty.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst. While rst=0:
  - FIFO, S1 and response buffer are emptied.
  - cache_addr=0, rsp_valid=0, rsp_addr/rsp_data/rsp_hit=0.
  - hit_cnt=miss_cnt=0, busy=0.
  - req_ready=0, and it goes to 1 on the first posedge after rst rises.
- Reset mid-operation discards all in-flight requests and responses without notifying the consumer. The cache clears itself on the same rst.
- Request FIFO:
  - Push when req_valid&&req_ready.
  - req_ready=(fifo count<REQ_DEPTH), computed from registered count. A pop in the same cycle does not raise ready.
  - Pointers wrap modulo REQ_DEPTH.
  - No bypass: a request pushed at edge k is issuable no earlier than edge k+1.
- Issue stage S1 (registers s1_valid, cache_addr):
  - At each posedge, let occ = response buffer occupancy, pop = rsp_valid&&rsp_ready, push = s1_valid.
  - Issue when the FIFO is non-empty and (occ - pop + push) < 2. Issuing moves the FIFO head into cache_addr and sets s1_valid=1. Otherwise s1_valid=0.
  - cache_addr holds its last value when not issuing. The cache then re-accesses that address every negedge. This is a repeated hit and is idempotent on LRU.
  - After reset, idle accesses target address 0, so address 0 gets allocated in the cache.
- Capture:
  - At every posedge with s1_valid=1, push {cache_addr, cache_out, cache_hit} into the 2-entry response buffer.
  - Space is guaranteed by the issue rule. S1 never stalls, so each result is captured exactly once, from the first negedge access.
  - On the same edge, hit_cnt++ if cache_hit=1, else miss_cnt++. Both counters saturate at all-ones.
- Response buffer:
  - 2-entry FIFO; the head drives rsp_*.
  - Pop on rsp_valid&&rsp_ready. Push and pop may occur on the same edge.
  - Responses leave in request order.
- Latency and throughput:
  - Accept at edge k, issue at edge k+1, cache negedge in cycle k+1, capture at edge k+2.
  - rsp_valid is high during cycle k+2, which is the minimum.
  - Sustained throughput is 1 per cycle while rsp_ready=1.
- Backpressure: when rsp_ready=0, issue stops once occ reaches 2. The FIFO then fills and req_ready drops.
- busy = (fifo count!=0) || s1_valid || rsp_valid.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W=32, DATA_W=32, INDEX_LSB=2, INDEX_MSB=3, TAG_LSB=4.
  - typedef rsp_t {addr, data, hit}.
- One natural sub-module: sync_fifo (parameterised width/depth, count output). Instantiate it twice:
  - request FIFO: width 32, depth REQ_DEPTH;
  - response buffer: width $bits(rsp_t), depth 2.

Test Plan:
- Reset, then request 0x40 with rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_addr=0x40, rsp_data=0x10, rsp_hit=0; miss_cnt=1. Repeat 0x40 -> rsp_hit=1, rsp_data=0x10, hit_cnt=1.
- Issue the index-0 conflict sequence 0x40, 0x80, 0xC0, 0x40 back-to-back -> hits 0,0,0,0; data 0x10, 0x20, 0x30, 0x10; 4 responses on consecutive cycles; miss_cnt=4.
- Hold rsp_ready=0 and send 8 requests with REQ_DEPTH=4 -> exactly 2 responses are buffered, req_ready=0 after the 4th FIFO entry. Release rsp_ready -> all 8 responses arrive in order, no duplicates, hit flags are the first-access values.
- Send 0x44 at cycle 10, then deassert rst asynchronously mid-cycle 11 -> rsp_valid, counters and busy are 0 immediately. After release, 0x44 reports a miss.
- Preload hit_cnt near saturation (2^CNT_W hits, small CNT_W=4 build) -> hit_cnt sticks at 15 and miss_cnt is unaffected.
- Toggle rsp_ready randomly with continuous req_valid -> the response stream matches a reference queue model.
